mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates one single-port data RAM between the CPU memory stage and an IO loader, with locked IO bursts.
// Latency: grants and mem* outputs are combinational; RAM read data and ioRValid arrive one cycle after the grant.
// Backpressure: a denied CPU sees cpuStall and holds its request; a denied IO retries and gains forced priority after MAXWAIT denials.
module mem_port_arbiter #(
   parameter int WIDTH     = 24,
   parameter int ADDRWIDTH = 24,
   parameter int MAXWAIT   = 4,
   parameter int BURSTLEN  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 startIO,
   input  logic                 cpuReq,
   input  logic                 cpuWe,
   input  logic [ADDRWIDTH-1:0] cpuAddr,
   input  logic [WIDTH-1:0]     cpuWData,
   output logic                 cpuStall,
   output logic [WIDTH-1:0]     cpuRData,
   input  logic                 ioReq,
   input  logic                 ioWe,
   input  logic [ADDRWIDTH-1:0] ioAddr,
   input  logic [WIDTH-1:0]     ioWData,
   output logic                 ioGrant,
   output logic [WIDTH-1:0]     ioRData,
   output logic                 ioRValid,
   output logic                 memWe,
   output logic [ADDRWIDTH-1:0] memAddr,
   output logic [WIDTH-1:0]     memWData,
   input  logic [WIDTH-1:0]     memRData,
   output logic                 burstBusy
);

   typedef enum logic {
      SHARED = 1'b0,
      BURST  = 1'b1
   } state_t;

   localparam logic [3:0] MAX_WAIT_C  = 4'(MAXWAIT);
   localparam logic [7:0] LAST_BEAT_C = 8'(BURSTLEN - 1);

   state_t     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       io_rvalid_q, io_rvalid_d;

   logic       cpu_grant;
   logic       io_grant;

   // Grant decision, memory port mux and next-state computation from current state and inputs.
   always_comb begin
      cpu_grant   = 1'b0;
      io_grant    = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      io_rvalid_d = 1'b0;

      // Reset suppresses every grant so nothing reaches the RAM while it is held.
      if (!reset) begin
         case (state_q)
            SHARED: begin
               // CPU wins unless IO has already been turned away MAXWAIT times.
               if (cpuReq && (wait_cnt_q < MAX_WAIT_C)) begin
                  cpu_grant = 1'b1;
               end else if (ioReq) begin
                  io_grant = 1'b1;
               end
            end
            BURST: begin
               // The burst owns the port; CPU waits even when IO idles.
               io_grant = ioReq;
            end
            default: begin
               cpu_grant = 1'b0;
               io_grant  = 1'b0;
            end
         endcase
      end

      if (reset) begin
         state_d     = SHARED;
         wait_cnt_d  = 4'd0;
         beat_cnt_d  = 8'd0;
         io_rvalid_d = 1'b0;
      end else begin
         // Denial counter: counts consecutive refused IO requests, saturating.
         if (ioReq && !io_grant) begin
            if (wait_cnt_q >= MAX_WAIT_C) begin
               wait_cnt_d = MAX_WAIT_C;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end else begin
            wait_cnt_d = 4'd0;
         end

         case (state_q)
            SHARED: begin
               if (startIO) begin
                  state_d    = BURST;
                  beat_cnt_d = 8'd0;
               end
            end
            BURST: begin
               // startIO is deliberately ignored here; only granted beats advance the burst.
               if (io_grant) begin
                  if (beat_cnt_q == LAST_BEAT_C) begin
                     state_d    = SHARED;
                     beat_cnt_d = 8'd0;
                  end else begin
                     beat_cnt_d = beat_cnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d    = SHARED;
               beat_cnt_d = 8'd0;
            end
         endcase

         io_rvalid_d = io_grant && !ioWe;
      end
   end

   // Drive the RAM port with the granted requester, or idle zeros when nobody is granted.
   always_comb begin
      memWe    = 1'b0;
      memAddr  = '0;
      memWData = '0;
      if (io_grant) begin
         memWe    = ioWe;
         memAddr  = ioAddr;
         memWData = ioWData;
      end else if (cpu_grant) begin
         memWe    = cpuWe;
         memAddr  = cpuAddr;
         memWData = cpuWData;
      end
   end

   assign cpuStall  = cpuReq && !cpu_grant;
   assign ioGrant   = io_grant;
   assign ioRValid  = io_rvalid_q;
   assign burstBusy = (state_q == BURST) && !reset;
   assign cpuRData  = memRData;
   assign ioRData   = memRData;

   // State register with synchronous reset folded into the next-state logic.
   always_ff @(posedge clock) begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      io_rvalid_q <= io_rvalid_d;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a RAM model and a rule-level reference model.
// Latency: checks combinational outputs mid-cycle and registered outputs one cycle after grants.
// Backpressure: exercises CPU stall, IO forced priority and locked bursts with ioReq gaps.
module tb_mem_port_arbiter;
   localparam int W  = 24;
   localparam int A  = 24;
   localparam int MW = 4;
   localparam int BL = 16;

   logic         clock = 1'b0;
   logic         reset, startIO, cpuReq, cpuWe, ioReq, ioWe;
   logic [A-1:0] cpuAddr, ioAddr, memAddr;
   logic [W-1:0] cpuWData, ioWData, memWData, cpuRData, ioRData;
   logic [W-1:0] memRData = '0;
   logic         cpuStall, ioGrant, ioRValid, memWe, burstBusy;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.WIDTH(W), .ADDRWIDTH(A), .MAXWAIT(MW), .BURSTLEN(BL)) dut (
      .clock(clock), .reset(reset), .startIO(startIO),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
      .cpuStall(cpuStall), .cpuRData(cpuRData),
      .ioReq(ioReq), .ioWe(ioWe), .ioAddr(ioAddr), .ioWData(ioWData),
      .ioGrant(ioGrant), .ioRData(ioRData), .ioRValid(ioRValid),
      .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memRData(memRData),
      .burstBusy(burstBusy)
   );

   always #5 clock = ~clock;

   // Single-port RAM with one-cycle read latency, read-before-write.
   logic [W-1:0] ram [256];
   always @(posedge clock) begin
      memRData <= ram[memAddr[7:0]];
      if (memWe) ram[memAddr[7:0]] <= memWData;
   end

   // Reference model: burst flag, number of consecutive IO refusals, beats done in the burst.
   bit           m_burst, n_burst;
   int           m_denied, n_denied, m_beats, n_beats;
   bit           m_rvalid, n_rvalid;
   logic [W-1:0] m_rdata, n_rdata;
   logic [W-1:0] mref [256];
   bit           n_we;
   logic [7:0]   n_waddr;
   logic [W-1:0] n_wdat;
   bit           e_io, e_cpu;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Settle inputs, predict this cycle's outputs from the rules, compare, and prepare next model state.
   task automatic eval();
      bit           e_we;
      logic [A-1:0] e_addr;
      logic [W-1:0] e_dat;
      #3;
      e_io  = 0;
      e_cpu = 0;
      if (!reset) begin
         if (m_burst)                         e_io  = ioReq;
         else if (cpuReq && m_denied < MW)    e_cpu = 1;
         else if (ioReq)                      e_io  = 1;
      end
      e_we   = e_io ? ioWe    : (e_cpu ? cpuWe    : 1'b0);
      e_addr = e_io ? ioAddr  : (e_cpu ? cpuAddr  : '0);
      e_dat  = e_io ? ioWData : (e_cpu ? cpuWData : '0);
      chk("cpuStall", 32'(cpuStall), 32'(cpuReq && !e_cpu));
      chk("ioGrant", 32'(ioGrant), 32'(e_io));
      chk("burstBusy", 32'(burstBusy), 32'(m_burst && !reset));
      chk("memWe", 32'(memWe), 32'(e_we));
      chk("memAddr", 32'(memAddr), 32'(e_addr));
      chk("memWData", 32'(memWData), 32'(e_dat));
      chk("ioRValid", 32'(ioRValid), 32'(m_rvalid));
      if (m_rvalid) chk("ioRData", 32'(ioRData), 32'(m_rdata));
      if (reset) begin
         n_burst = 0; n_denied = 0; n_beats = 0; n_rvalid = 0;
      end else begin
         n_burst  = m_burst;
         n_beats  = m_beats;
         n_denied = (ioReq && !e_io) ? ((m_denied + 1 > MW) ? MW : m_denied + 1) : 0;
         if (!m_burst && startIO) begin
            n_burst = 1; n_beats = 0;
         end else if (m_burst && e_io) begin
            n_beats = m_beats + 1;
            if (n_beats == BL) begin
               n_burst = 0; n_beats = 0;
            end
         end
         n_rvalid = e_io && !ioWe;
      end
      n_rdata = mref[e_addr[7:0]];
      n_we    = e_we;
      n_waddr = e_addr[7:0];
      n_wdat  = e_dat;
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
      m_burst  = n_burst;
      m_denied = n_denied;
      m_beats  = n_beats;
      m_rvalid = n_rvalid;
      m_rdata  = n_rdata;
      if (n_we) mref[n_waddr] = n_wdat;
   endtask

   task automatic step();
      eval();
      advance();
   endtask

   task automatic set_in(input bit r, input bit s, input bit cr, input bit cw, input logic [A-1:0] ca,
                         input bit ir, input bit iw, input logic [A-1:0] ia);
      reset = r; startIO = s; cpuReq = cr; cpuWe = cw; cpuAddr = ca;
      ioReq = ir; ioWe = iw; ioAddr = ia;
   endtask

   typedef struct {
      bit           rst, sio, creq, cwe;
      logic [A-1:0] caddr;
      bit           ireq, iwe;
      logic [A-1:0] iaddr;
      bit           x_stall, x_grant, x_busy, x_we;
      logic [A-1:0] x_addr;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants, busy_cyc, k;
      for (int i = 0; i < 256; i++) begin
         ram[i]  = '0;
         mref[i] = '0;
      end
      cpuWData = 24'h123456;
      ioWData  = 24'h654321;
      //          rst sio cr cw caddr     ir iw iaddr     stl gnt bsy we addr
      vecs[0]  = '{1, 0, 1, 0, 24'h100, 1, 0, 24'h010, 1, 0, 0, 0, 24'h000};
      vecs[1]  = '{0, 0, 1, 1, 24'h100, 1, 0, 24'h010, 0, 0, 0, 1, 24'h100};
      vecs[2]  = '{0, 0, 1, 1, 24'h100, 1, 0, 24'h010, 0, 0, 0, 1, 24'h100};
      vecs[3]  = '{0, 0, 1, 1, 24'h100, 1, 0, 24'h010, 0, 0, 0, 1, 24'h100};
      vecs[4]  = '{0, 0, 1, 1, 24'h100, 1, 0, 24'h010, 0, 0, 0, 1, 24'h100};
      vecs[5]  = '{0, 0, 1, 1, 24'h100, 1, 0, 24'h010, 1, 1, 0, 0, 24'h010};
      vecs[6]  = '{0, 0, 0, 0, 24'h100, 0, 0, 24'h010, 0, 0, 0, 0, 24'h000};
      vecs[7]  = '{0, 0, 1, 0, 24'h020, 0, 0, 24'h010, 0, 0, 0, 0, 24'h020};
      vecs[8]  = '{0, 1, 1, 0, 24'h020, 1, 1, 24'h011, 0, 0, 0, 0, 24'h020};
      vecs[9]  = '{0, 0, 1, 0, 24'h020, 1, 1, 24'h011, 1, 1, 1, 1, 24'h011};
      vecs[10] = '{0, 0, 1, 0, 24'h020, 0, 1, 24'h011, 1, 0, 1, 0, 24'h000};
      vecs[11] = '{0, 1, 0, 0, 24'h020, 0, 0, 24'h011, 0, 0, 1, 0, 24'h000};
      vecs[12] = '{1, 0, 1, 0, 24'h020, 1, 0, 24'h011, 1, 0, 0, 0, 24'h000};
      vecs[13] = '{0, 0, 1, 0, 24'h020, 1, 0, 24'h011, 0, 0, 0, 0, 24'h020};

      // Initial reset cycle before the model is trusted.
      set_in(1, 0, 0, 0, '0, 0, 0, '0);
      @(posedge clock); #1;
      m_burst = 0; m_denied = 0; m_beats = 0; m_rvalid = 0; m_rdata = '0;

      // Table-driven vectors with hand-computed expectations.
      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i].rst, vecs[i].sio, vecs[i].creq, vecs[i].cwe, vecs[i].caddr,
                vecs[i].ireq, vecs[i].iwe, vecs[i].iaddr);
         eval();
         chk($sformatf("vec%0d_stall", i), 32'(cpuStall), 32'(vecs[i].x_stall));
         chk($sformatf("vec%0d_grant", i), 32'(ioGrant), 32'(vecs[i].x_grant));
         chk($sformatf("vec%0d_busy", i), 32'(burstBusy), 32'(vecs[i].x_busy));
         chk($sformatf("vec%0d_we", i), 32'(memWe), 32'(vecs[i].x_we));
         chk($sformatf("vec%0d_addr", i), 32'(memAddr), 32'(vecs[i].x_addr));
         advance();
      end

      // Contention: IO forced through every fifth cycle.
      set_in(1, 0, 0, 0, '0, 0, 0, '0);
      step();
      grants = 0;
      for (int c = 1; c <= 20; c++) begin
         set_in(0, 0, 1, 0, 24'h030, 1, 0, 24'h031);
         eval();
         chk($sformatf("contend_c%0d", c), 32'(ioGrant), 32'((c % 5) == 0));
         if (ioGrant) grants++;
         advance();
      end
      chk("contend_grants", 32'(grants), 32'd4);

      // CPU-only traffic: never stalls, address passes straight through.
      for (int c = 0; c < 4; c++) begin
         set_in(0, 0, 1, 0, 24'(32'h200 + c), 0, 0, '0);
         eval();
         chk("cpu_only_stall", 32'(cpuStall), 32'd0);
         chk("cpu_only_addr", 32'(memAddr), 32'(32'h200 + c));
         advance();
      end

      // Preload 0xABCDEF at 0x10 through the CPU.
      cpuWData = 24'hABCDEF;
      set_in(0, 0, 1, 1, 24'h010, 0, 0, '0);
      step();

      // Burst of 16 with a three-cycle ioReq gap; CPU keeps requesting.
      set_in(0, 1, 1, 0, 24'h020, 1, 1, 24'h040);
      eval();
      chk("start_cpu_wins", 32'(cpuStall), 32'd0);
      advance();
      grants = 0; busy_cyc = 0;
      for (int n = 0; n < 40; n++) begin
         set_in(0, 0, 1, 0, 24'h020, !(n >= 5 && n < 8), 1, 24'(32'h40 + n));
         eval();
         if (!burstBusy) begin
            chk("post_burst_cpu", 32'(cpuStall), 32'd0);
            advance();
            break;
         end
         busy_cyc++;
         if (ioGrant) grants++;
         advance();
      end
      chk("burst_busy_cycles", 32'(busy_cyc), 32'd19);
      chk("burst_grants", 32'(grants), 32'd16);

      // IO read: data and valid one cycle after the grant.
      set_in(0, 0, 0, 0, '0, 1, 0, 24'h010);
      eval();
      chk("io_read_grant", 32'(ioGrant), 32'd1);
      advance();
      set_in(0, 0, 0, 0, '0, 0, 0, '0);
      eval();
      chk("io_read_valid", 32'(ioRValid), 32'd1);
      chk("io_read_data", 32'(ioRData), 32'hABCDEF);
      advance();

      // Reset at beat 7 abandons the burst.
      set_in(0, 1, 0, 0, '0, 0, 0, '0);
      step();
      for (int b = 0; b < 7; b++) begin
         set_in(0, 0, 0, 0, '0, 1, 0, 24'h010);
         step();
      end
      set_in(1, 0, 1, 0, 24'h050, 1, 0, 24'h010);
      eval();
      chk("rst_grant", 32'(ioGrant), 32'd0);
      advance();
      set_in(0, 0, 1, 0, 24'h050, 1, 0, 24'h010);
      eval();
      chk("rst_busy", 32'(burstBusy), 32'd0);
      chk("rst_rvalid", 32'(ioRValid), 32'd0);
      chk("rst_cpu", 32'(cpuStall), 32'd0);
      advance();

      // Randomised traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         k = $urandom_range(0, 99);
         cpuWData = 24'($urandom);
         ioWData  = 24'($urandom);
         set_in(k == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                24'($urandom_range(0, 255)), $urandom_range(0, 2) != 0, 1'($urandom),
                24'($urandom_range(0, 255)));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
